// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel prefetch path.
// Holds the fetch FSM state type, pixel/word widths and default colours.
package pixel_pkg;

    localparam int PIX_W  = 24;
    localparam int WORD_W = 48;

    localparam logic [PIX_W-1:0] BG_COLOR_DEF = 24'h000000;
    localparam logic [PIX_W-1:0] UF_COLOR_DEF = 24'hFF00FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pixel_word_fifo.sv
// Word FIFO absorbing pixel-memory read latency.
// Ports: clk, rst_n, flush (empties the FIFO, wins over push/pop),
// push/din, pop/dout (head word), count, empty.
module pixel_word_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign dout    = mem[rp];
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pixel_prefetch.sv
// Prefetches packed pixel words ahead of DISP_EN and unpacks them to RGB.
// Ports: CLOCK_25, RST_N, FRAME_START, LINE_START, DISP_EN, MEM_Q in;
// MEM_ADDR, MEM_RDEN, RGB, DISP_EN_Q, UNDERFLOW, FRAME_HASH out.
// Optional macro PIXEL_HASH_EN builds the frame-signature accumulator.
module pixel_prefetch
    import pixel_pkg::*;
#(
    parameter int               IMG_W      = 8,
    parameter int               IMG_H      = 8,
    parameter int               ADDR_W     = 11,
    parameter int               MEM_LAT    = 2,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [PIX_W-1:0] BG_COLOR   = BG_COLOR_DEF,
    parameter logic [PIX_W-1:0] UF_COLOR   = UF_COLOR_DEF
) (
    input  logic              CLOCK_25,
    input  logic              RST_N,
    input  logic              FRAME_START,
    input  logic              LINE_START,
    input  logic              DISP_EN,
    input  logic [WORD_W-1:0] MEM_Q,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RDEN,
    output logic [PIX_W-1:0]  RGB,
    output logic              DISP_EN_Q,
    output logic              UNDERFLOW,
    output logic [31:0]       FRAME_HASH
);

    localparam int HALF = IMG_W / 2;
    localparam int RW   = $clog2(IMG_H + 1) + 1;
    localparam int CLW  = $clog2(IMG_W + 1);
    localparam int WCW  = $clog2(HALF + 1);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int OW   = $clog2(FIFO_DEPTH + MEM_LAT + 2) + 1;

    fetch_state_t      state;
    logic [RW-1:0]     row;
    logic [RW-1:0]     row_next;
    logic              row_ok;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] rd_addr;
    logic [WCW-1:0]    words;
    logic [CLW-1:0]    col;
    logic [MEM_LAT-1:0] vld;
    logic [OW-1:0]     inflight;
    logic              can_issue;

    logic              f_push;
    logic              f_pop;
    logic [WORD_W-1:0] f_head;
    logic [CW-1:0]     f_count;
    logic              f_empty;

    logic              in_img;
    logic              uf_evt;
    logic [PIX_W-1:0]  pix;

    // All-ones row means "no row"; the next LINE_START wraps it to 0.
    // Rows saturate at IMG_H so extra lines stay outside the image.
    always_comb begin
        if (FRAME_START) begin
            row_next = '0;
        end else if (row == RW'(IMG_H)) begin
            row_next = row;
        end else begin
            row_next = row + 1'b1;
        end
    end

    assign row_ok   = (row < RW'(IMG_H));
    assign row_base = ADDR_W'(row_next) * ADDR_W'(HALF);

    // Reads on the bus and in the latency pipe both count as in flight,
    // so FIFO space is reserved before a word can come back.
    always_comb begin
        inflight = OW'(MEM_RDEN);
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + OW'(vld[i]);
        end
    end

    assign can_issue = (OW'(f_count) + inflight) < OW'(FIFO_DEPTH);
    assign f_push    = vld[MEM_LAT-1] && !LINE_START;

    pixel_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_25),
        .rst_n (RST_N),
        .flush (LINE_START),
        .push  (f_push),
        .din   (MEM_Q),
        .pop   (f_pop),
        .dout  (f_head),
        .count (f_count),
        .empty (f_empty)
    );

    always_ff @(posedge CLOCK_25 or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            row      <= '1;
            words    <= '0;
            rd_addr  <= '0;
            MEM_ADDR <= '0;
            MEM_RDEN <= 1'b0;
            vld      <= '0;
        end else begin
            MEM_RDEN <= 1'b0;
            vld      <= (vld << 1) | MEM_LAT'(MEM_RDEN);
            if (FRAME_START && !LINE_START) begin
                row <= '1;
            end
            if (LINE_START) begin
                row     <= row_next;
                words   <= '0;
                rd_addr <= row_base;
                vld     <= '0;
                state   <= (row_next < RW'(IMG_H)) ? FETCH : IDLE;
            end else begin
                unique case (state)
                    FETCH: begin
                        if (can_issue) begin
                            MEM_RDEN <= 1'b1;
                            MEM_ADDR <= rd_addr;
                            rd_addr  <= rd_addr + 1'b1;
                            words    <= words + 1'b1;
                            if (words == WCW'(HALF - 1)) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (inflight == '0) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Column parity is the half-select: even columns show the low
    // pixel, odd columns the high pixel and release the word.
    always_comb begin
        in_img = DISP_EN && row_ok && (col < CLW'(IMG_W));
        pix    = BG_COLOR;
        f_pop  = 1'b0;
        uf_evt = 1'b0;
        if (in_img) begin
            if (f_empty) begin
                pix    = UF_COLOR;
                uf_evt = 1'b1;
            end else begin
                pix   = col[0] ? f_head[WORD_W-1:PIX_W]
                               : f_head[PIX_W-1:0];
                f_pop = col[0];
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge RST_N) begin
        if (!RST_N) begin
            RGB       <= '0;
            DISP_EN_Q <= 1'b0;
            UNDERFLOW <= 1'b0;
            col       <= '0;
        end else begin
            DISP_EN_Q <= DISP_EN;
            RGB       <= DISP_EN ? pix : '0;
            if (FRAME_START) begin
                UNDERFLOW <= 1'b0;
            end else if (uf_evt) begin
                UNDERFLOW <= 1'b1;
            end
            if (LINE_START) begin
                col <= '0;
            end else if (in_img) begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef PIXEL_HASH_EN
    logic [31:0] acc;

    always_ff @(posedge CLOCK_25 or negedge RST_N) begin
        if (!RST_N) begin
            acc        <= '0;
            FRAME_HASH <= '0;
        end else if (FRAME_START) begin
            FRAME_HASH <= acc;
            acc        <= '0;
        end else if (in_img) begin
            acc <= acc + 32'(pix);
        end
    end
`else
    assign FRAME_HASH = '0;
`endif

endmodule
